// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync, blank and
// line/frame start pulses, all advancing only on pixel clock-enable cycles.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [10:0] hcnt,
  output logic [10:0] vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic        r_lineStart;
  logic        r_frameStart;

  logic        w_hLast;
  logic        w_vLast;
  logic [10:0] w_hNext;
  logic [10:0] w_vNext;

  // Wrap on ">=" so a counter can never escape its range, even from a bad state.
  assign w_hLast = (r_hcnt >= H_LAST);
  assign w_vLast = (r_vcnt >= V_LAST);

  always_comb begin
    w_hNext = w_hLast ? 11'd0 : r_hcnt + 11'd1;
    w_vNext = r_vcnt;
    if (w_hLast) begin
      w_vNext = w_vLast ? 11'd0 : r_vcnt + 11'd1;
    end
  end

  // Sync and blank are derived from the next counter values so they land
  // in the same cycle as the count they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt       <= 11'd0;
      r_vcnt       <= 11'd0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_blank      <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
      if (pix_ce) begin
        r_hcnt       <= w_hNext;
        r_vcnt       <= w_vNext;
        r_hsync      <= !((w_hNext >= HS_START) && (w_hNext < HS_END));
        r_vsync      <= !((w_vNext >= VS_START) && (w_vNext < VS_END));
        r_blank      <= (w_hNext >= H_VIS) || (w_vNext >= V_VIS);
        r_lineStart  <= w_hLast;
        r_frameStart <= w_hLast && w_vLast;
      end
    end
  end

  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for line-level behaviour and
// a tiny-timing instance so whole frames fit in a short run.
module tb_vga_sync_gen;

  localparam int B_HV = 8, B_HFP = 2, B_HS = 3, B_HBP = 3;
  localparam int B_VV = 6, B_VFP = 1, B_VS = 2, B_VBP = 2;
  localparam int B_FRAME = (B_HV + B_HFP + B_HS + B_HBP) * (B_VV + B_VFP + B_VS + B_VBP);

  logic clk = 1'b0;
  logic rst;
  logic pixCe;

  logic [10:0] hcntA, vcntA, hcntB, vcntB;
  logic hsyncA, vsyncA, blankA, lsA, fsA;
  logic hsyncB, vsyncB, blankB, lsB, fsB;

  always #5 clk = ~clk;

  vga_sync_gen dutA (
    .clk(clk), .rst(rst), .pix_ce(pixCe),
    .hcnt(hcntA), .vcnt(vcntA), .hsync(hsyncA), .vsync(vsyncA),
    .blank(blankA), .line_start(lsA), .frame_start(fsA)
  );

  vga_sync_gen #(
    .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
  ) dutB (
    .clk(clk), .rst(rst), .pix_ce(pixCe),
    .hcnt(hcntB), .vcnt(vcntB), .hsync(hsyncB), .vsync(vsyncB),
    .blank(blankB), .line_start(lsB), .frame_start(fsB)
  );

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  // Model: pixel count since reset; position is plain div/mod of it.
  longint nA = 0, nB = 0;
  bit expLsA, expFsA, expLsB, expFsB;

  int hLowCnt, hLowFirst, hLowLast, lineCntA, vLowCntB;
  longint fsTimes[$];

  task automatic cmp(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input longint n, input bit eLs, input bit eFs,
                             input int hv, input int hfp, input int hs, input int hbp,
                             input int vv, input int vfp, input int vs, input int vbp,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hsy, input logic vsy, input logic bl,
                             input logic ls, input logic fs);
    int ht, vt, h, v;
    ht = hv + hfp + hs + hbp;
    vt = vv + vfp + vs + vbp;
    h  = int'(n % longint'(ht));
    v  = int'((n / longint'(ht)) % longint'(vt));
    cmp({tag, ".hcnt"}, hc, 11'(h));
    cmp({tag, ".vcnt"}, vc, 11'(v));
    cmp({tag, ".hsync"}, {10'd0, hsy}, {10'd0, !(h >= hv + hfp && h < hv + hfp + hs)});
    cmp({tag, ".vsync"}, {10'd0, vsy}, {10'd0, !(v >= vv + vfp && v < vv + vfp + vs)});
    cmp({tag, ".blank"}, {10'd0, bl}, {10'd0, (h >= hv) || (v >= vv)});
    cmp({tag, ".line_start"}, {10'd0, ls}, {10'd0, eLs});
    cmp({tag, ".frame_start"}, {10'd0, fs}, {10'd0, eFs});
  endtask

  task automatic modelStep(input bit r, input bit ce, input int ht, input int vt,
                           inout longint n, output bit eLs, output bit eFs);
    eLs = 1'b0;
    eFs = 1'b0;
    if (r) begin
      n = 0;
    end else if (ce) begin
      n++;
      eLs = (n % longint'(ht)) == 0;
      eFs = (n % longint'(ht * vt)) == 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ce);
    rst   = r;
    pixCe = ce;
    @(posedge clk);
    cyc++;
    modelStep(r, ce, 800, 525, nA, expLsA, expFsA);
    modelStep(r, ce, B_HV + B_HFP + B_HS + B_HBP, B_VV + B_VFP + B_VS + B_VBP, nB, expLsB, expFsB);
    #1;
    checkOutput("A", nA, expLsA, expFsA, 640, 16, 96, 48, 480, 10, 2, 33,
                hcntA, vcntA, hsyncA, vsyncA, blankA, lsA, fsA);
    checkOutput("B", nB, expLsB, expFsB, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP,
                hcntB, vcntB, hsyncB, vsyncB, blankB, lsB, fsB);
    if (fsB === 1'b1) fsTimes.push_back(cyc);
  endtask

  task automatic checkPeriods(input string tag, input longint period, input int minPulses);
    cmp({tag, ".pulses_enough"}, {10'd0, fsTimes.size() >= minPulses}, 11'd1);
    for (int i = 1; i < fsTimes.size(); i++) begin
      cmp({tag, ".period"}, 11'(fsTimes[i] - fsTimes[i-1]), 11'(period));
    end
  endtask

  initial begin
    rst   = 1'b1;
    pixCe = 1'b0;

    // reset, including reset while pix_ce is high
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);

    // continuous counting: two full default lines, several small frames
    hLowCnt = 0; hLowFirst = -1; hLowLast = -1; lineCntA = 0; vLowCntB = 0;
    fsTimes.delete();
    for (int i = 0; i < 1700; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (nA < 800 && hsyncA === 1'b0) begin
        if (hLowFirst < 0) hLowFirst = int'(hcntA);
        hLowLast = int'(hcntA);
        hLowCnt++;
      end
      if (lsA === 1'b1) lineCntA++;
      if (nB > 0 && nB <= B_FRAME && vsyncB === 1'b0) vLowCntB++;
    end
    cmp("A.hsync_low_count", 11'(hLowCnt), 11'd96);
    cmp("A.hsync_low_first", 11'(hLowFirst), 11'd656);
    cmp("A.hsync_low_last", 11'(hLowLast), 11'd751);
    cmp("A.line_pulses", 11'(lineCntA), 11'd2);
    cmp("B.vsync_low_count", 11'(vLowCntB), 11'(B_VS * (B_HV + B_HFP + B_HS + B_HBP)));
    checkPeriods("B.ce_full", longint'(B_FRAME), 5);

    // random clock-enable with rare resets
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)));
    end

    // alternating pix_ce doubles the frame period in clocks
    applyStimulus(1'b1, 1'b0);
    fsTimes.delete();
    for (int i = 0; i < 4 * B_FRAME; i++) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
    end
    checkPeriods("B.ce_alt", longint'(2 * B_FRAME), 3);

    // mid-frame reset at (700,2) on the default instance, then resume
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 2300; i++) applyStimulus(1'b0, 1'b1);
    cmp("A.pre_reset_h", hcntA, 11'd700);
    cmp("A.pre_reset_v", vcntA, 11'd2);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    cmp("A.resume_h", hcntA, 11'd1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
